// File: rtl/rs_chien_ctrl.sv
// Chien search sequencer: accepts one locator job, launches the root sweep,
// counts root hits over the valid candidate positions and reports the result.
module rs_chien_ctrl #(
  parameter int unsigned SYMB_WIDTH      = 8,
  parameter int unsigned ROOTS_PER_CYCLE = 16,
  parameter int unsigned CYCLES_NUM      = 16,
  parameter int unsigned N_ROOTS         = (1 << SYMB_WIDTH) - 1,
  parameter int unsigned T_LEN           = 8,
  localparam int unsigned DEG_W          = $clog2(T_LEN + 1),
  localparam int unsigned CNT_W          = $clog2(N_ROOTS + 1)
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       s_vld,
  output logic                       s_rdy,
  input  logic [DEG_W:0]             s_deg,
  output logic                       chien_start,
  input  logic                       hit_vld,
  input  logic [ROOTS_PER_CYCLE-1:0] hit_mask,
  output logic                       m_vld,
  input  logic                       m_rdy,
  output logic [CNT_W-1:0]           m_err_cnt,
  output logic [DEG_W:0]             m_deg,
  output logic                       m_fail,
  output logic                       hit_unexp
);

  localparam int unsigned SDEG_W = DEG_W + 1;
  localparam int unsigned BEAT_W = (CYCLES_NUM > 1) ? $clog2(CYCLES_NUM) : 1;
  localparam int unsigned PC_W   = $clog2(ROOTS_PER_CYCLE + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_START  = 2'd1,
    ST_SEARCH = 2'd2,
    ST_REPORT = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                s_rdy_q, s_rdy_d;
  logic                chien_start_q, chien_start_d;
  logic                m_vld_q, m_vld_d;
  logic [CNT_W-1:0]    m_err_cnt_q, m_err_cnt_d;
  logic [SDEG_W-1:0]   m_deg_q, m_deg_d;
  logic                m_fail_q, m_fail_d;
  logic                hit_unexp_q, hit_unexp_d;

  logic                accept;
  logic                deg_bad;
  logic                last_beat;
  logic                beat_in;
  logic [PC_W-1:0]     pc;
  logic [CNT_W-1:0]    sum;

  assign accept    = s_vld && s_rdy_q;
  assign deg_bad   = (s_deg == '0) || (s_deg > SDEG_W'(T_LEN));
  assign last_beat = (beat_q == BEAT_W'(CYCLES_NUM - 1));
  assign beat_in   = hit_vld && (state_q == ST_SEARCH);
  assign sum       = cnt_q + CNT_W'(pc);

  // Popcount of this beat's lanes, skipping positions past the last valid root
  always_comb begin
    pc = '0;
    for (int unsigned i = 0; i < ROOTS_PER_CYCLE; i++) begin
      if (hit_mask[i] && ((32'(beat_q) * ROOTS_PER_CYCLE + i) < N_ROOTS)) begin
        pc = pc + PC_W'(1);
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (accept) state_d = deg_bad ? ST_REPORT : ST_START;
      ST_START:  state_d = ST_SEARCH;
      ST_SEARCH: if (hit_vld && last_beat) state_d = ST_REPORT;
      ST_REPORT: if (m_rdy) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Datapath and registered outputs; invalid degrees report failure without a sweep
  always_comb begin
    cnt_d         = cnt_q;
    beat_d        = beat_q;
    m_err_cnt_d   = m_err_cnt_q;
    m_deg_d       = m_deg_q;
    m_fail_d      = m_fail_q;
    s_rdy_d       = (state_d == ST_IDLE);
    chien_start_d = (state_d == ST_START);
    m_vld_d       = (state_d == ST_REPORT);
    hit_unexp_d   = hit_vld && (state_q != ST_SEARCH);

    if (accept) begin
      m_deg_d = s_deg;
      cnt_d   = '0;
      beat_d  = '0;
      if (deg_bad) begin
        m_err_cnt_d = '0;
        m_fail_d    = 1'b1;
      end
    end

    if (beat_in) begin
      cnt_d  = sum;
      beat_d = beat_q + BEAT_W'(1);
      if (last_beat) begin
        m_err_cnt_d = sum;
        m_fail_d    = (32'(sum) != 32'(m_deg_q));
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_q         <= '0;
      beat_q        <= '0;
      s_rdy_q       <= 1'b0;
      chien_start_q <= 1'b0;
      m_vld_q       <= 1'b0;
      m_err_cnt_q   <= '0;
      m_deg_q       <= '0;
      m_fail_q      <= 1'b0;
      hit_unexp_q   <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      beat_q        <= beat_d;
      s_rdy_q       <= s_rdy_d;
      chien_start_q <= chien_start_d;
      m_vld_q       <= m_vld_d;
      m_err_cnt_q   <= m_err_cnt_d;
      m_deg_q       <= m_deg_d;
      m_fail_q      <= m_fail_d;
      hit_unexp_q   <= hit_unexp_d;
    end
  end

  assign s_rdy       = s_rdy_q;
  assign chien_start = chien_start_q;
  assign m_vld       = m_vld_q;
  assign m_err_cnt   = m_err_cnt_q;
  assign m_deg       = m_deg_q;
  assign m_fail      = m_fail_q;
  assign hit_unexp   = hit_unexp_q;

endmodule

// File: tb/tb_rs_chien_ctrl.sv
// Directed bench for rs_chien_ctrl: hand-computed root counts, fail flags,
// handshake timing, stray beats and mid-sweep reset.
module tb_rs_chien_ctrl;

  logic        aclk;
  logic        aresetn;
  logic        s_vld;
  logic        s_rdy;
  logic [4:0]  s_deg;
  logic        chien_start;
  logic        hit_vld;
  logic [15:0] hit_mask;
  logic        m_vld;
  logic        m_rdy;
  logic [7:0]  m_err_cnt;
  logic [4:0]  m_deg;
  logic        m_fail;
  logic        hit_unexp;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int unexp_cnt = 0;
  logic [15:0] masks [16];

  rs_chien_ctrl dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .s_vld       (s_vld),
    .s_rdy       (s_rdy),
    .s_deg       (s_deg),
    .chien_start (chien_start),
    .hit_vld     (hit_vld),
    .hit_mask    (hit_mask),
    .m_vld       (m_vld),
    .m_rdy       (m_rdy),
    .m_err_cnt   (m_err_cnt),
    .m_deg       (m_deg),
    .m_fail      (m_fail),
    .hit_unexp   (hit_unexp)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  always @(posedge aclk) begin
    if (chien_start === 1'b1) start_cnt = start_cnt + 1;
    if (hit_unexp === 1'b1) unexp_cnt = unexp_cnt + 1;
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_masks();
    for (int b = 0; b < 16; b++) masks[b] = 16'h0000;
  endtask

  task automatic start_job(input logic [4:0] deg);
    chk("s_rdy_before_job", 32'(s_rdy), 32'd1);
    s_vld = 1'b1;
    s_deg = deg;
    tick();
    s_vld = 1'b0;
  endtask

  task automatic run_sweep(input bit gaps);
    for (int b = 0; b < 16; b++) begin
      hit_vld  = 1'b1;
      hit_mask = masks[b];
      tick();
      hit_vld  = 1'b0;
      hit_mask = 16'h0000;
      if (gaps) repeat (b % 6) tick();
    end
  endtask

  task automatic finish_report();
    m_rdy = 1'b1;
    tick();
    m_rdy = 1'b0;
    chk("m_vld_after_hs", 32'(m_vld), 32'd0);
    chk("s_rdy_after_hs", 32'(s_rdy), 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_s_rdy"}, 32'(s_rdy), 32'd0);
    chk({tag, "_chien_start"}, 32'(chien_start), 32'd0);
    chk({tag, "_m_vld"}, 32'(m_vld), 32'd0);
    chk({tag, "_m_err_cnt"}, 32'(m_err_cnt), 32'd0);
    chk({tag, "_m_deg"}, 32'(m_deg), 32'd0);
    chk({tag, "_m_fail"}, 32'(m_fail), 32'd0);
    chk({tag, "_hit_unexp"}, 32'(hit_unexp), 32'd0);
  endtask

  initial begin
    aresetn  = 1'b0;
    s_vld    = 1'b0;
    s_deg    = 5'd0;
    hit_vld  = 1'b0;
    hit_mask = 16'h0000;
    m_rdy    = 1'b0;
    clear_masks();

    // Reset values
    repeat (3) tick();
    chk_reset_vals("rst");
    aresetn = 1'b1;
    tick();
    chk("s_rdy_after_release", 32'(s_rdy), 32'd1);

    // deg=3, hits in beats 2, 7, 15 lane 0
    start_cnt = 0;
    unexp_cnt = 0;
    masks[2] = 16'h0001; masks[7] = 16'h0001; masks[15] = 16'h0001;
    start_job(5'd3);
    chk("t1_chien_start_hi", 32'(chien_start), 32'd1);
    chk("t1_s_rdy_busy", 32'(s_rdy), 32'd0);
    tick();
    chk("t1_chien_start_lo", 32'(chien_start), 32'd0);
    run_sweep(1'b0);
    chk("t1_m_vld", 32'(m_vld), 32'd1);
    chk("t1_cnt", 32'(m_err_cnt), 32'd3);
    chk("t1_fail", 32'(m_fail), 32'd0);
    chk("t1_deg", 32'(m_deg), 32'd3);
    chk("t1_start_pulses", 32'(start_cnt), 32'd1);
    chk("t1_no_unexp", 32'(unexp_cnt), 32'd0);
    finish_report();

    // deg=9 exceeds T_LEN: immediate failure report, no sweep
    start_cnt = 0;
    start_job(5'd9);
    chk("t2_m_vld", 32'(m_vld), 32'd1);
    chk("t2_fail", 32'(m_fail), 32'd1);
    chk("t2_cnt", 32'(m_err_cnt), 32'd0);
    chk("t2_deg", 32'(m_deg), 32'd9);
    finish_report();
    chk("t2_no_start", 32'(start_cnt), 32'd0);

    // deg=0 behaves the same
    start_job(5'd0);
    chk("t2b_m_vld", 32'(m_vld), 32'd1);
    chk("t2b_fail", 32'(m_fail), 32'd1);
    chk("t2b_cnt", 32'(m_err_cnt), 32'd0);
    finish_report();
    chk("t2b_no_start", 32'(start_cnt), 32'd0);

    // deg=2, full mask on last beat: position 255 is not a candidate
    clear_masks();
    masks[15] = 16'hFFFF;
    start_job(5'd2);
    tick();
    run_sweep(1'b0);
    chk("t3_m_vld", 32'(m_vld), 32'd1);
    chk("t3_cnt", 32'(m_err_cnt), 32'd15);
    chk("t3_fail", 32'(m_fail), 32'd1);
    finish_report();

    // Gapped beats and long back-pressure on the result
    clear_masks();
    masks[2] = 16'h0001; masks[7] = 16'h0001; masks[15] = 16'h0001;
    start_cnt = 0;
    start_job(5'd3);
    tick();
    run_sweep(1'b1);
    for (int i = 0; i < 10; i++) begin
      chk("t4_hold_m_vld", 32'(m_vld), 32'd1);
      chk("t4_hold_cnt", 32'(m_err_cnt), 32'd3);
      chk("t4_hold_fail", 32'(m_fail), 32'd0);
      chk("t4_hold_s_rdy", 32'(s_rdy), 32'd0);
      s_vld = 1'b1;
      s_deg = 5'd1;
      tick();
    end
    s_vld = 1'b0;
    chk("t4_start_pulses", 32'(start_cnt), 32'd1);
    finish_report();

    // Stray beat in IDLE, then a one-root job
    unexp_cnt = 0;
    hit_vld  = 1'b1;
    hit_mask = 16'hFFFF;
    tick();
    hit_vld  = 1'b0;
    hit_mask = 16'h0000;
    chk("t5_unexp_hi", 32'(hit_unexp), 32'd1);
    tick();
    chk("t5_unexp_lo", 32'(hit_unexp), 32'd0);
    chk("t5_unexp_count", 32'(unexp_cnt), 32'd1);
    clear_masks();
    masks[4] = 16'h0008;
    start_job(5'd1);
    tick();
    run_sweep(1'b0);
    chk("t5_cnt", 32'(m_err_cnt), 32'd1);
    chk("t5_fail", 32'(m_fail), 32'd0);
    finish_report();

    // Reset at beat 7 abandons the sweep
    clear_masks();
    masks[2] = 16'h0001; masks[7] = 16'h0001; masks[15] = 16'h0001;
    start_job(5'd3);
    tick();
    for (int b = 0; b < 7; b++) begin
      hit_vld  = 1'b1;
      hit_mask = masks[b];
      tick();
    end
    hit_vld  = 1'b0;
    hit_mask = 16'h0000;
    aresetn  = 1'b0;
    #1;
    chk_reset_vals("t6");
    tick();
    aresetn = 1'b1;
    tick();
    chk("t6_s_rdy_release", 32'(s_rdy), 32'd1);
    chk("t6_m_vld_release", 32'(m_vld), 32'd0);
    start_job(5'd3);
    tick();
    run_sweep(1'b0);
    chk("t6_m_vld", 32'(m_vld), 32'd1);
    chk("t6_cnt", 32'(m_err_cnt), 32'd3);
    chk("t6_fail", 32'(m_fail), 32'd0);
    finish_report();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
